// File: rtl/m_user_input_pkg.sv
// Shared command codes, button indices and repeat-FSM state type for the
// Connect-Four button path (consumed by m_user_input and m_ai_play).
package m_user_input_pkg;

  localparam int NUM_BTN = 3;

  localparam int BTN_INC = 0;
  localparam int BTN_DEC = 1;
  localparam int BTN_OK  = 2;

  localparam logic [3:0] USER_INPUT_IDLE = 4'b0000;
  localparam logic [3:0] USER_INPUT_INC  = 4'b0001;
  localparam logic [3:0] USER_INPUT_DEC  = 4'b0010;
  localparam logic [3:0] USER_INPUT_OK   = 4'b0100;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } rpt_state_e;

endpackage

// File: rtl/m_user_input_if.sv
// Button/command bundle between the board buttons and the game logic.
interface m_user_input_if;
  logic [2:0] i_btn;
  logic [3:0] o_user_input;
  logic [2:0] o_held;

  modport master (output i_btn, input o_user_input, input o_held);
  modport slave  (input i_btn, output o_user_input, output o_held);
endinterface

// File: rtl/m_btn_debounce.sv
// Two-flop synchroniser plus counter debounce for one push-button.
// o_rise is a registered one-cycle strobe on the stable level's 0->1 flip.
module m_btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 100000
) (
  input  logic w_clk,
  input  logic w_rst,
  input  logic i_btn,
  output logic o_level,
  output logic o_rise
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [1:0]       sync_q;
  logic             level_q, level_d;
  logic             rise_q, rise_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             differ, flip;

  always_comb begin
    differ  = sync_q[1] ^ level_q;
    flip    = differ && (cnt_q == CNT_W'(DEBOUNCE_CYCLES));
    cnt_d   = '0;
    if (differ && !flip) cnt_d = cnt_q + CNT_W'(1);
    level_d = level_q ^ flip;
    rise_d  = flip & ~level_q;
  end

  // sync -> count -> stable level
  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], i_btn};
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
    end
  end

  assign o_level = level_q;
  assign o_rise  = rise_q;

endmodule

// File: rtl/m_user_input.sv
// Debounces INC/DEC/OK, auto-repeats INC/DEC while held, and emits a
// registered single-cycle one-hot command (OK > DEC > INC).
module m_user_input
  import m_user_input_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 100000,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_PERIOD   = 10000000
) (
  input  logic           w_clk,
  input  logic           w_rst,
  m_user_input_if.slave  bus
);

  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);

  logic [NUM_BTN-1:0] level, rise;
  logic [NUM_BTN-1:0] req;
  logic [1:0]         rpt_req;
  rpt_state_e         state_q [2];
  rpt_state_e         state_d [2];
  logic [RPT_W-1:0]   cnt_q   [2];
  logic [RPT_W-1:0]   cnt_d   [2];
  logic [3:0]         out_q, out_d;

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
    m_btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .w_clk   (w_clk),
      .w_rst   (w_rst),
      .i_btn   (bus.i_btn[g]),
      .o_level (level[g]),
      .o_rise  (rise[g])
    );
  end

  // Index 0 is INC and index 1 is DEC, matching the button bit order.
  // A release always wins over a request due in the same cycle.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      rpt_req[i] = 1'b0;
      case (state_q[i])
        IDLE: begin
          if (rise[i]) begin
            rpt_req[i] = 1'b1;
            state_d[i] = DELAY;
            cnt_d[i]   = '0;
          end
        end
        DELAY: begin
          if (!level[i]) begin
            state_d[i] = IDLE;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == RPT_W'(REPEAT_DELAY - 1)) begin
            rpt_req[i] = 1'b1;
            state_d[i] = REPEAT;
            cnt_d[i]   = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + RPT_W'(1);
          end
        end
        REPEAT: begin
          if (!level[i]) begin
            state_d[i] = IDLE;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == RPT_W'(REPEAT_PERIOD - 1)) begin
            rpt_req[i] = 1'b1;
            cnt_d[i]   = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + RPT_W'(1);
          end
        end
        default: begin
          state_d[i] = IDLE;
          cnt_d[i]   = '0;
        end
      endcase
    end
  end

  always_comb begin
    req   = {rise[BTN_OK], rpt_req[BTN_DEC], rpt_req[BTN_INC]};
    out_d = USER_INPUT_IDLE;
    if (req[BTN_OK])       out_d = USER_INPUT_OK;
    else if (req[BTN_DEC]) out_d = USER_INPUT_DEC;
    else if (req[BTN_INC]) out_d = USER_INPUT_INC;
  end

  // FSM state / output register
  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      for (int i = 0; i < 2; i++) begin
        state_q[i] <= IDLE;
        cnt_q[i]   <= '0;
      end
      out_q <= USER_INPUT_IDLE;
    end else begin
      for (int i = 0; i < 2; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      out_q <= out_d;
    end
  end

  assign bus.o_user_input = out_q;
  assign bus.o_held       = level;

endmodule
